// File: rtl/vproc_mem_responder_if.sv
// Request/response bundle between a vproc_top memory initiator (master)
// and vproc_mem_responder (slave).
interface vproc_mem_responder_if #(
  parameter int unsigned MEM_W = 32
);
  logic                   mem_req;
  logic [31:0]            mem_addr;
  logic                   mem_we;
  logic [MEM_W/8-1:0]     mem_be;
  logic [MEM_W-1:0]       mem_wdata;
  logic                   mem_rvalid;
  logic                   mem_err;
  logic [MEM_W-1:0]       mem_rdata;

  modport master (
    output mem_req, mem_addr, mem_we, mem_be, mem_wdata,
    input  mem_rvalid, mem_err, mem_rdata
  );

  modport slave (
    input  mem_req, mem_addr, mem_we, mem_be, mem_wdata,
    output mem_rvalid, mem_err, mem_rdata
  );
endinterface

// File: rtl/vproc_mem_responder.sv
// Fixed-latency, fully pipelined SRAM responder for the vproc mem_req/mem_rvalid port.
// Optional feature: define VPROC_MEM_RESP_ERR_EN to flag offsets >= MEM_SZ as errors.
module vproc_mem_responder #(
  parameter int unsigned MEM_W       = 32,
  parameter int unsigned MEM_SZ      = 262144,
  parameter int unsigned MEM_LATENCY = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  vproc_mem_responder_if.slave mem_if
);

  localparam int unsigned BE_W  = MEM_W / 8;
  localparam int unsigned OFF_W = $clog2(BE_W);
  localparam int unsigned SZ_W  = $clog2(MEM_SZ);
  localparam int unsigned WORDS = MEM_SZ / BE_W;
  localparam int unsigned IDX_W = SZ_W - OFF_W;

  logic [MEM_W-1:0]       mem_q [WORDS];

  logic [31:0]            offset;
  logic [IDX_W-1:0]       idx;
  logic                   err_d;
  logic                   rd_en;
  logic                   wr_en;
  logic [MEM_W-1:0]       rdata_d;
  logic                   unused_offset;

  logic [MEM_LATENCY-1:0] vld_q;
  logic [MEM_LATENCY-1:0] err_q;
  logic [MEM_W-1:0]       rdata_q [MEM_LATENCY];

  assign offset = mem_if.mem_addr - BASE_ADDR;
  assign idx    = offset[SZ_W-1:OFF_W];

`ifdef VPROC_MEM_RESP_ERR_EN
  assign err_d = mem_if.mem_req && (offset[31:SZ_W] != '0);
`else
  // Upper offset bits are dropped, so out-of-range addresses alias into the array.
  assign err_d = 1'b0;
`endif

  assign unused_offset = ^{offset[OFF_W-1:0], offset[31:SZ_W]};

  // A request presented while reset is held is not accepted, so it must not write.
  assign wr_en = mem_if.mem_req &&  mem_if.mem_we && !err_d && rst_ni;
  assign rd_en = mem_if.mem_req && !mem_if.mem_we && !err_d;

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      for (int b = 0; b < BE_W; b++) begin
        if (mem_if.mem_be[b]) begin
          mem_q[idx][b*8 +: 8] <= mem_if.mem_wdata[b*8 +: 8];
        end
      end
    end
  end

  // Read data is captured at the accepting edge; later writes cannot disturb it.
  always_comb begin
    rdata_d = '0;
    if (rd_en) begin
      rdata_d = mem_q[idx];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q <= '0;
      err_q <= '0;
      for (int k = 0; k < MEM_LATENCY; k++) begin
        rdata_q[k] <= '0;
      end
    end else begin
      vld_q[0]   <= mem_if.mem_req;
      err_q[0]   <= err_d;
      rdata_q[0] <= rdata_d;
      for (int k = 1; k < MEM_LATENCY; k++) begin
        vld_q[k]   <= vld_q[k-1];
        err_q[k]   <= err_q[k-1];
        rdata_q[k] <= rdata_q[k-1];
      end
    end
  end

  assign mem_if.mem_rvalid = vld_q[MEM_LATENCY-1];
  assign mem_if.mem_err    = err_q[MEM_LATENCY-1];
  assign mem_if.mem_rdata  = rdata_q[MEM_LATENCY-1];

endmodule

// File: tb/tb_vproc_mem_responder.sv
// Scoreboard bench: one stimulus stream drives a latency-1 and a latency-3 responder,
// expected responses come from a byte-level memory model.
module tb_vproc_mem_responder;

  localparam int          LAT_A  = 1;
  localparam int          LAT_B  = 3;
  localparam int unsigned MEM_SZ = 262144;
  localparam int          WIN    = 64;
  localparam logic [31:0] BASE   = 32'h0000_0000;

  typedef struct {
    int          due;
    logic        err;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;

  logic        rv [2];
  logic        er [2];
  logic [31:0] rd [2];

  exp_t        sbq [2][$];
  logic [31:0] model_mem [int unsigned];
  exp_t        mon_e;
  int          ec = 0;
  int          compared = 0;
  int          mismatched = 0;

  always #5 clk = ~clk;
  always @(posedge clk) ec <= ec + 1;

  vproc_mem_responder_if #(.MEM_W(32)) if_a ();
  vproc_mem_responder_if #(.MEM_W(32)) if_b ();

  assign if_a.mem_req = req;   assign if_b.mem_req = req;
  assign if_a.mem_addr = addr; assign if_b.mem_addr = addr;
  assign if_a.mem_we = we;     assign if_b.mem_we = we;
  assign if_a.mem_be = be;     assign if_b.mem_be = be;
  assign if_a.mem_wdata = wdata; assign if_b.mem_wdata = wdata;

  assign rv[0] = if_a.mem_rvalid; assign er[0] = if_a.mem_err; assign rd[0] = if_a.mem_rdata;
  assign rv[1] = if_b.mem_rvalid; assign er[1] = if_b.mem_err; assign rd[1] = if_b.mem_rdata;

  vproc_mem_responder #(
    .MEM_W(32), .MEM_SZ(MEM_SZ), .MEM_LATENCY(LAT_A), .BASE_ADDR(BASE)
  ) u_dut_a (
    .clk_i(clk), .rst_ni(rst_n), .mem_if(if_a)
  );

  vproc_mem_responder #(
    .MEM_W(32), .MEM_SZ(MEM_SZ), .MEM_LATENCY(LAT_B), .BASE_ADDR(BASE)
  ) u_dut_b (
    .clk_i(clk), .rst_ni(rst_n), .mem_if(if_b)
  );

  function automatic int lat_of(input int p);
    return (p == 0) ? LAT_A : LAT_B;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_outputs_zero(input string nm);
    for (int p = 0; p < 2; p++) begin
      chk($sformatf("%s_p%0d_rvalid", nm, p), {31'b0, rv[p]}, 32'h0);
      chk($sformatf("%s_p%0d_err", nm, p), {31'b0, er[p]}, 32'h0);
      chk($sformatf("%s_p%0d_rdata", nm, p), rd[p], 32'h0);
    end
  endtask

  // Reference: array of words addressed by (offset mod size)/4, bytes merged per enable.
  task automatic issue(input logic w, input logic [31:0] a, input logic [3:0] b,
                       input logic [31:0] d);
    exp_t        e;
    logic [31:0] off;
    logic [31:0] word;
    int unsigned widx;
    logic        bad;
    @(negedge clk);
    req = 1'b1; we = w; addr = a; be = b; wdata = d;
    off  = a - BASE;
    bad  = 1'b0;
`ifdef VPROC_MEM_RESP_ERR_EN
    bad  = (off >= MEM_SZ);
`endif
    widx = (off % MEM_SZ) / 4;
    e.err  = bad;
    e.data = 32'h0;
    if (!bad) begin
      word = model_mem.exists(widx) ? model_mem[widx] : 32'h0;
      if (w) begin
        for (int i = 0; i < 4; i++) begin
          if (b[i]) word[8*i +: 8] = d[8*i +: 8];
        end
        model_mem[widx] = word;
      end else begin
        e.data = word;
      end
    end
    for (int p = 0; p < 2; p++) begin
      e.due = ec + lat_of(p);
      sbq[p].push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      req = 1'b0;
    end
  endtask

  task automatic pulse_reset(input string nm);
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 32'h10;
    #2 rst_n = 1'b0;
    sbq[0].delete();
    sbq[1].delete();
    #1 chk_outputs_zero({nm, "_async"});
    @(negedge clk);
    chk_outputs_zero({nm, "_held"});
    #2 rst_n = 1'b1;
    req = 1'b0;
  endtask

  always @(negedge clk) begin
    for (int p = 0; p < 2; p++) begin
      if (rv[p]) begin
        compared++;
        if (sbq[p].size() == 0) begin
          mismatched++;
          $display("FAIL unexpected_rvalid p%0d: got rvalid=1 at cycle %0d expected none", p, ec);
        end else begin
          mon_e = sbq[p].pop_front();
          if (mon_e.due != ec || er[p] !== mon_e.err || rd[p] !== mon_e.data) begin
            mismatched++;
            $display("FAIL resp p%0d: got cycle %0d err %0b data %h expected cycle %0d err %0b data %h",
                     p, ec, er[p], rd[p], mon_e.due, mon_e.err, mon_e.data);
          end
        end
      end else begin
        compared++;
        if (er[p] !== 1'b0 || rd[p] !== 32'h0) begin
          mismatched++;
          $display("FAIL idle_zero p%0d: got err %0b data %h expected err 0 data 0", p, er[p], rd[p]);
        end
        if (sbq[p].size() != 0 && sbq[p][0].due < ec) begin
          mon_e = sbq[p].pop_front();
          compared++;
          mismatched++;
          $display("FAIL missing_rvalid p%0d: got no response by cycle %0d expected at cycle %0d",
                   p, ec, mon_e.due);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion by %0t expected finish", $time);
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] a;
    req = 1'b1; we = 1'b0; addr = 32'h0; be = 4'h0; wdata = 32'h0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_outputs_zero("reset_hold");
    end
    req = 1'b0;
    #2 rst_n = 1'b1;

    for (int w = 0; w < WIN; w++) issue(1'b1, w * 4, 4'hF, $urandom);

    issue(1'b1, 32'h10, 4'hF, 32'hDEADBEEF);
    issue(1'b0, 32'h10, 4'h0, 32'h0);
    issue(1'b1, 32'h20, 4'hF, 32'hAAAAAAAA);
    issue(1'b1, 32'h20, 4'b0101, 32'h11223344);
    issue(1'b0, 32'h20, 4'h0, 32'h0);
    issue(1'b1, 32'h24, 4'h0, 32'hFFFFFFFF);
    issue(1'b0, 32'h24, 4'h0, 32'h0);
    idle(4);

    issue(1'b0, 32'h0, 4'h0, 32'h0);
    issue(1'b0, 32'h4, 4'h0, 32'h0);
    issue(1'b0, 32'h8, 4'h0, 32'h0);
    issue(1'b0, 32'hC, 4'h0, 32'h0);
    issue(1'b0, 32'h13, 4'h0, 32'h0);
    idle(4);

    issue(1'b1, 32'h0004_0000, 4'hF, 32'h5A5A1234);
    issue(1'b0, 32'h0004_0000, 4'h0, 32'h0);
    issue(1'b0, 32'h0, 4'h0, 32'h0);
    idle(4);

    issue(1'b0, 32'h10, 4'h0, 32'h0);
    issue(1'b0, 32'h14, 4'h0, 32'h0);
    pulse_reset("midflight");
    issue(1'b0, 32'h10, 4'h0, 32'h0);
    idle(5);

    for (int i = 0; i < 400; i++) begin
      if (i == 200) pulse_reset("random_rst");
      if ($urandom_range(0, 7) == 0) begin
        idle(1);
      end else begin
        a = ($urandom_range(0, 9) == 0) ? (32'($urandom_range(1, 16383)) << 18) : 32'h0;
        a = a | 32'($urandom_range(0, WIN * 4 - 1));
        issue(1'($urandom_range(0, 1)), a, 4'($urandom_range(0, 15)), $urandom);
      end
    end
    idle(LAT_B + 3);

    chk("drain_p0", 32'(sbq[0].size()), 32'h0);
    chk("drain_p1", 32'(sbq[1].size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
